// File: rtl/sim_ctrl_pkg.sv
// Shared encodings for the epidemic simulation controller: command types,
// controller FSM states and the popcount grouping.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_SEED  = 2'd0,
        CMD_STATE = 2'd1,
        CMD_CONN  = 2'd2,
        CMD_START = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_e;

    localparam int STEP_W    = 32;
    localparam int POP_GROUP = 16;

endpackage

// File: rtl/agent_popcount.sv
// Two-stage registered popcount of the agent state vector: stage 1 holds
// per-16-bit-group partial sums, stage 2 the total. A valid/tag rides along.
module agent_popcount
    import sim_ctrl_pkg::*;
#(
    parameter int W     = 100,
    parameter int TAG_W = 32,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [W-1:0]     i_bits,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic [CNT_W-1:0] o_count
);

    localparam int NG = (W + POP_GROUP - 1) / POP_GROUP;

    logic [NG*POP_GROUP-1:0] w_padded;
    logic [4:0]              w_part [NG];
    logic [4:0]              r_part [NG];
    logic                    r_valid1;
    logic [TAG_W-1:0]        r_tag1;
    logic [CNT_W-1:0]        w_total;
    logic                    r_valid2;
    logic [TAG_W-1:0]        r_tag2;
    logic [CNT_W-1:0]        r_count2;

    always_comb begin
        w_padded         = '0;
        w_padded[W-1:0]  = i_bits;
        for (int g = 0; g < NG; g++) begin
            w_part[g] = '0;
            for (int b = 0; b < POP_GROUP; b++) begin
                w_part[g] = w_part[g] + {4'd0, w_padded[g*POP_GROUP+b]};
            end
        end
    end

    // A group sum never exceeds W, so narrowing to CNT_W is lossless.
    always_comb begin
        w_total = '0;
        for (int g = 0; g < NG; g++) begin
            w_total = w_total + CNT_W'(r_part[g]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NG; g++) begin
                r_part[g] <= '0;
            end
            r_valid1 <= 1'b0;
            r_tag1   <= '0;
            r_valid2 <= 1'b0;
            r_tag2   <= '0;
            r_count2 <= '0;
        end else begin
            r_valid1 <= i_valid;
            r_valid2 <= r_valid1;
            if (i_valid) begin
                for (int g = 0; g < NG; g++) begin
                    r_part[g] <= w_part[g];
                end
                r_tag1 <= i_tag;
            end
            if (r_valid1) begin
                r_tag2   <= r_tag1;
                r_count2 <= w_total;
            end
        end
    end

    assign o_valid = r_valid2;
    assign o_tag   = r_tag2;
    assign o_count = r_count2;

endmodule

// File: rtl/epidemic_sim_ctrl.sv
// Controller for the agent array: decodes configuration commands onto the
// shared broadcast buses and runs N-step simulations with per-step infected counts.
module epidemic_sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int numAgents = 100,
    parameter int CNT_W     = $clog2(numAgents + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_type,
    input  logic [31:0]          cmd_addr,
    input  logic [31:0]          cmd_data,
    input  logic                 abort,
    output logic [31:0]          agent_addr,
    output logic [31:0]          seed_value,
    output logic                 load_seed,
    output logic                 init_state,
    output logic                 load_state,
    output logic [31:0]          conn_value,
    output logic [numAgents-1:0] conn_load,
    input  logic [numAgents-1:0] agent_state,
    output logic                 stat_valid,
    output logic [31:0]          stat_step,
    output logic [CNT_W-1:0]     stat_count,
    output logic                 busy,
    output logic                 done,
    output logic                 addr_err
);

    // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE outside reset, and there is no backpressure
    // on the stat_* stream.
    ctrl_state_e           r_state;
    ctrl_state_e           w_next;
    logic                  w_accept;
    logic                  w_addr_ok;
    logic                  w_last;
    logic                  w_sample;
    logic [numAgents-1:0]  w_onehot;

    logic [31:0]           r_addr;
    logic [31:0]           r_seed;
    logic                  r_init;
    logic [31:0]           r_conn;
    logic                  r_load_seed;
    logic                  r_load_state;
    logic [numAgents-1:0]  r_conn_load;
    logic [STEP_W-1:0]     r_step;
    logic [STEP_W-1:0]     r_last;
    logic                  r_drain;
    logic                  r_done;
    logic                  r_addr_err;

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_addr_ok = (cmd_addr < 32'(numAgents));
    assign w_onehot  = {{(numAgents-1){1'b0}}, 1'b1} << cmd_addr;
    assign w_last    = (r_step == r_last);
    assign w_sample  = (r_state == RUN) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_type != CMD_START) begin
                        w_next = LOAD;
                    end else if (cmd_data != 32'd0) begin
                        w_next = RUN;
                    end
                end
            end
            LOAD:    w_next = IDLE;
            RUN:     if (abort || w_last) w_next = DRAIN;
            DRAIN:   if (r_drain) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_seed       <= '0;
            r_init       <= 1'b0;
            r_conn       <= '0;
            r_load_seed  <= 1'b0;
            r_load_state <= 1'b0;
            r_conn_load  <= '0;
            r_step       <= '0;
            r_last       <= '0;
            r_drain      <= 1'b0;
            r_done       <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_load_seed  <= 1'b0;
            r_load_state <= 1'b0;
            r_conn_load  <= '0;
            r_done       <= 1'b0;
            // Strobes are registered at acceptance so they are high exactly in LOAD.
            if (w_accept) begin
                case (cmd_type)
                    CMD_SEED: begin
                        r_addr      <= cmd_addr;
                        r_seed      <= cmd_data;
                        r_load_seed <= w_addr_ok;
                    end
                    CMD_STATE: begin
                        r_addr       <= cmd_addr;
                        r_init       <= cmd_data[0];
                        r_load_state <= w_addr_ok;
                    end
                    CMD_CONN: begin
                        r_addr      <= cmd_addr;
                        r_conn      <= cmd_data;
                        r_conn_load <= w_addr_ok ? w_onehot : '0;
                    end
                    default: begin
                        r_step <= '0;
                        r_last <= cmd_data - 32'd1;
                        r_done <= (cmd_data == 32'd0);
                    end
                endcase
                if (cmd_type != CMD_START && !w_addr_ok) begin
                    r_addr_err <= 1'b1;
                end
            end
            if (w_sample) begin
                r_step <= r_step + 32'd1;
            end
            // Two DRAIN cycles let the last sample clear the popcount pipeline.
            r_drain <= (r_state == DRAIN) && !r_drain;
            if (r_state == DRAIN && r_drain) begin
                r_done <= 1'b1;
            end
        end
    end

    agent_popcount #(
        .W     (numAgents),
        .TAG_W (STEP_W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_sample),
        .i_tag   (r_step),
        .i_bits  (agent_state),
        .o_valid (stat_valid),
        .o_tag   (stat_step),
        .o_count (stat_count)
    );

    assign agent_addr = r_addr;
    assign seed_value = r_seed;
    assign init_state = r_init;
    assign conn_value = r_conn;
    assign load_seed  = r_load_seed;
    assign load_state = r_load_state;
    assign conn_load  = r_conn_load;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign addr_err   = r_addr_err;

endmodule
